dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data memory between two requesters: the RISC-V
//   core load/store port (C) and a DMA/debug port (D). It drives the memory
//   write-enable, address and write-data, and returns read data to the
//   requester that issued the read. The core normally wins; a starvation
//   counter guarantees the DMA port forward progress.
// PARAMETERS
//   ADDR_W    32  address width (full byte address, passed through unchanged)
//   DATA_W    32  data width
//   MAX_WAIT   4  DMA cycles lost to C before D gets priority (legal >= 1)
// PORTS
//   clk        in   1       clock, all state updates on posedge
//   rst_n      in   1       asynchronous active-low reset
//   c_req      in   1       core request valid (held until granted)
//   c_we       in   1       core write (1) / read (0)
//   c_addr     in   ADDR_W  core byte address
//   c_wdata    in   DATA_W  core write data
//   c_gnt      out  1       core request accepted this cycle (combinational)
//   c_rvalid   out  1       core read data valid (registered, 1-cycle pulse)
//   c_rdata    out  DATA_W  core read data (registered)
//   d_req/d_we/d_addr/d_wdata  in   as C, DMA port
//   d_gnt/d_rvalid/d_rdata     out  as C, DMA port
//   mem_we     out  1       memory write enable
//   mem_addr   out  ADDR_W  memory address
//   mem_wd     out  DATA_W  memory write data
//   mem_rd     in   DATA_W  memory read data (combinational read)
// BEHAVIOUR
// - Reset (rst_n low, async): pri=C_PRI, wait_cnt=0, c/d_rvalid=0, c/d_rdata=0.
//   A read accepted in the cycle reset asserts produces no rvalid.
// - FSM, 2 states: C_PRI (C wins if both request), D_PRI (D wins if both).
// - Grant (comb): only-one-request -> that requester; both -> per state.
//   At most one gnt high per cycle; no req -> no gnt.
// - Mux: mem_addr/mem_wd from granted port; from C when idle.
//   mem_we = granted port's we; 0 when no grant.
// - Write: commits at the posedge ending the grant cycle; no rvalid.
// - Read: mem_rd captured at the same posedge into the port's rdata;
//   rvalid high for exactly the next cycle. rdata holds until the next read.
//   Latency: req+gnt in cycle N -> rvalid/rdata in cycle N+1.
//   Back-to-back reads every cycle are supported; C and D rdata are independent.
// - Starvation: wait_cnt (clog2(MAX_WAIT+1) bits) increments each cycle with
//   d_req & ~d_gnt, saturates at MAX_WAIT. Cleared when d_gnt or ~d_req.
//   C_PRI -> D_PRI when wait_cnt==MAX_WAIT. D_PRI -> C_PRI after one D grant,
//   or when d_req drops.
// - Requester rule: req/we/addr/wdata stable while req high and gnt low;
//   the arbiter never drops a held request.
// TESTING
// 1 Reset: rst_n=0 mid-read -> all rvalid=0, rdata=0, mem_we=0 immediately;
//   no rvalid after release.
// 2 C write 0xDEADBEEF @0x10, then C read @0x10 -> c_rvalid next cycle,
//   c_rdata=0xDEADBEEF, d_rvalid=0.
// 3 D-only read @0x20 (mem holds 0x1234) -> d_gnt same cycle,
//   d_rvalid+1, d_rdata=0x1234.
// 4 C and D request every cycle, MAX_WAIT=4 -> C granted 4 cycles,
//   D granted 5th, pattern repeats; never two gnt high.
// 5 Simultaneous C write 0xA @0x0 and D read @0x0 -> C first; D then
//   reads 0xA.
// 6 D drops req while wait_cnt=3 -> wait_cnt=0, state stays C_PRI.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port (core / DMA) arbiter for a single-port data memory with
//            fixed core priority and a starvation counter for the DMA port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // core load/store port
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    // DMA / debug port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    // memory side
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] C_MAX_WAIT = WAIT_W'(MAX_WAIT);

    typedef enum logic [0:0] {
        ST_C_PRI = 1'b0,
        ST_D_PRI = 1'b1
    } state_t;

    state_t              r_state;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_c_rvalid;
    logic                r_d_rvalid;
    logic [DATA_W-1:0]   r_c_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    logic                w_c_gnt;
    logic                w_d_gnt;
    logic [WAIT_W-1:0]   w_wait_nxt;

    // D only loses a tie while the FSM holds core priority
    always_comb begin
        w_c_gnt = c_req & (~d_req | (r_state == ST_C_PRI));
        w_d_gnt = d_req & ~w_c_gnt;
    end

    always_comb begin
        w_wait_nxt = '0;
        if (d_req && !w_d_gnt) begin
            w_wait_nxt = (r_wait_cnt == C_MAX_WAIT) ? C_MAX_WAIT
                                                    : r_wait_cnt + 1'b1;
        end
    end

    assign c_gnt    = w_c_gnt;
    assign d_gnt    = w_d_gnt;
    assign mem_we   = (w_c_gnt & c_we) | (w_d_gnt & d_we);
    assign mem_addr = w_d_gnt ? d_addr  : c_addr;
    assign mem_wd   = w_d_gnt ? d_wdata : c_wdata;

    // Switching on the incremented count lets D win on the very next cycle
    // once it has lost MAX_WAIT times in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_C_PRI;
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
            case (r_state)
                ST_C_PRI: if (w_wait_nxt == C_MAX_WAIT) r_state <= ST_D_PRI;
                ST_D_PRI: if (w_d_gnt || !d_req)        r_state <= ST_C_PRI;
                default:                                r_state <= ST_C_PRI;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_c_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_c_rvalid <= w_c_gnt & ~c_we;
            r_d_rvalid <= w_d_gnt & ~d_we;
            if (w_c_gnt && !c_we) r_c_rdata <= mem_rd;
            if (w_d_gnt && !d_we) r_d_rdata <= mem_rd;
        end
    end

    assign c_rvalid = r_c_rvalid;
    assign c_rdata  = r_c_rdata;
    assign d_rvalid = r_d_rvalid;
    assign d_rdata  = r_d_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter (directed vectors + model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [31:0] c_rdata, d_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 8) ? 32'h0000_1234 : (32'h5A00_0000 | 32'(i));
    endfunction

    // Memory: combinational read, write on posedge
    logic [31:0] mem [0:63];
    assign mem_rd = mem[mem_addr[7:2]];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
        end
    end

    // Behavioural model: D wins a tie once it has lost MAX_WAIT cycles in a row
    logic [31:0] m_mem [0:63];
    int          m_lost;
    logic        m_cv, m_dv, n_cv, n_dv, e_cg, e_dg;
    logic [31:0] m_cr, m_dr, n_cr, n_dr;
    int          n_lost;

    initial begin
        for (int i = 0; i < 64; i++) m_mem[i] = init_word(i);
        m_lost = 0; m_cv = 0; m_dv = 0; m_cr = '0; m_dr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_lost = 0; m_cv = 0; m_dv = 0; m_cr = '0; m_dr = '0;
            end
            e_cg = c_req && (!d_req || m_lost < MAX_WAIT);
            e_dg = d_req && !e_cg;
            check("m_c_gnt",    32'(c_gnt),    32'(e_cg));
            check("m_d_gnt",    32'(d_gnt),    32'(e_dg));
            check("m_mem_we",   32'(mem_we),   32'((e_cg && c_we) || (e_dg && d_we)));
            check("m_mem_addr", mem_addr,      e_dg ? d_addr : c_addr);
            check("m_mem_wd",   mem_wd,        e_dg ? d_wdata : c_wdata);
            check("m_c_rvalid", 32'(c_rvalid), 32'(m_cv));
            check("m_c_rdata",  c_rdata,       m_cr);
            check("m_d_rvalid", 32'(d_rvalid), 32'(m_dv));
            check("m_d_rdata",  d_rdata,       m_dr);
            n_cv = e_cg && !c_we;
            n_dv = e_dg && !d_we;
            n_cr = n_cv ? m_mem[c_addr[7:2]] : m_cr;
            n_dr = n_dv ? m_mem[d_addr[7:2]] : m_dr;
            n_lost = (d_req && !e_dg) ? ((m_lost + 1 > MAX_WAIT) ? MAX_WAIT : m_lost + 1) : 0;
            @(posedge clk);
            if (rst_n) begin
                if (e_cg && c_we) m_mem[c_addr[7:2]] = c_wdata;
                if (e_dg && d_we) m_mem[d_addr[7:2]] = d_wdata;
                m_cv = n_cv; m_dv = n_dv; m_cr = n_cr; m_dr = n_dr; m_lost = n_lost;
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_c(input logic req, input logic we, input logic [31:0] a, input logic [31:0] wd);
        c_req = req; c_we = we; c_addr = a; c_wdata = wd;
    endtask

    task automatic drive_d(input logic req, input logic we, input logic [31:0] a, input logic [31:0] wd);
        d_req = req; d_we = we; d_addr = a; d_wdata = wd;
    endtask

    initial begin
        rst_n = 1'b1;
        drive_c(0, 0, 0, 0);
        drive_d(0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_c_rvalid", 32'(c_rvalid), 32'd0);
        check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        check("rst_c_rdata",  c_rdata, 32'd0);
        check("rst_d_rdata",  d_rdata, 32'd0);
        check("rst_mem_we",   32'(mem_we), 32'd0);
        cyc; cyc;
        rst_n = 1'b1;

        // core write then read back
        cyc; drive_c(1, 1, 32'h10, 32'hDEAD_BEEF);
        #1 check("t2_wr_gnt", 32'(c_gnt), 32'd1);
        check("t2_wr_we", 32'(mem_we), 32'd1);
        cyc; drive_c(1, 0, 32'h10, 32'h0);
        cyc; drive_c(0, 0, 0, 0);
        #1 check("t2_c_rvalid", 32'(c_rvalid), 32'd1);
        check("t2_c_rdata", c_rdata, 32'hDEAD_BEEF);
        check("t2_d_rvalid", 32'(d_rvalid), 32'd0);

        // DMA-only read
        cyc; drive_d(1, 0, 32'h20, 32'h0);
        #1 check("t3_d_gnt", 32'(d_gnt), 32'd1);
        cyc; drive_d(0, 0, 0, 0);
        #1 check("t3_d_rvalid", 32'(d_rvalid), 32'd1);
        check("t3_d_rdata", d_rdata, 32'h0000_1234);

        // continuous contention: C C C C D repeating
        cyc; drive_c(1, 0, 32'h4, 0); drive_d(1, 0, 32'h8, 0);
        for (int i = 0; i < 10; i++) begin
            #1 check("t4_d_gnt", 32'(d_gnt), 32'(i % 5 == 4));
            check("t4_c_gnt", 32'(c_gnt), 32'(i % 5 != 4));
            cyc;
        end

        // DMA drops request after 3 losses: counter restarts from zero
        for (int i = 0; i < 3; i++) begin
            #1 check("t6_pre_c_gnt", 32'(c_gnt), 32'd1);
            cyc;
        end
        drive_d(0, 0, 0, 0);
        #1 check("t6_drop_c_gnt", 32'(c_gnt), 32'd1);
        cyc; drive_d(1, 0, 32'h8, 0);
        for (int i = 0; i < 5; i++) begin
            #1 check("t6_d_gnt", 32'(d_gnt), 32'(i == 4));
            cyc;
        end
        drive_c(0, 0, 0, 0); drive_d(0, 0, 0, 0);

        // simultaneous C write and D read of the same word
        cyc; drive_c(1, 1, 32'h0, 32'hA); drive_d(1, 0, 32'h0, 0);
        #1 check("t5_c_gnt", 32'(c_gnt), 32'd1);
        check("t5_d_gnt", 32'(d_gnt), 32'd0);
        cyc; drive_c(0, 0, 0, 0);
        #1 check("t5_d_gnt2", 32'(d_gnt), 32'd1);
        cyc; drive_d(0, 0, 0, 0);
        #1 check("t5_d_rvalid", 32'(d_rvalid), 32'd1);
        check("t5_d_rdata", d_rdata, 32'hA);

        // asynchronous reset in the middle of reads
        cyc; drive_c(1, 0, 32'h10, 0);
        cyc;
        #1 check("t1_pre_rvalid", 32'(c_rvalid), 32'd1);
        rst_n = 1'b0;
        #1 check("t1_c_rvalid", 32'(c_rvalid), 32'd0);
        check("t1_c_rdata", c_rdata, 32'd0);
        check("t1_d_rdata", d_rdata, 32'd0);
        check("t1_mem_we", 32'(mem_we), 32'd0);
        cyc; drive_c(0, 0, 0, 0);
        #1 check("t1_no_rvalid", 32'(c_rvalid), 32'd0);
        cyc; rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc;
            check("t1_post_rvalid", 32'(c_rvalid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
